// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the ram_ctrl request/fill controller.
// Contents: ram_ctrl_state_t, the controller FSM state encoding.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_ctrl.sv
// ram_ctrl: front end for a single-port ram. It accepts read/write requests
// with a valid/ready handshake, returns read data with a valid/ready
// handshake, and can fill the whole memory with one value.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_rw_                    1 = read, 0 = write
//   req_addr, req_wdata        request address and write data
//   resp_valid/resp_ready      read response handshake
//   resp_rdata                 read data, zero whenever resp_valid is low
//   fill_start, fill_data      start a whole-memory fill with fill_data
//   fill_done                  one-cycle pulse in the first IDLE cycle after a fill
//   busy                       high whenever the FSM is not in IDLE
//   ram_en_, ram_rw_           ram enable (active low), ram read/write select
//   ram_addr, ram_wdata        ram address and write data
//   ram_rdata                  ram read data (latency 0 or 1 cycle per OUTREG)
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATA   = 16,
  parameter int unsigned DEPTH  = 4,
  parameter bit          OUTREG = 1'b0,
  localparam int unsigned ADDR  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_rw_,
  input  logic [ADDR-1:0] req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DATA-1:0] resp_rdata,
  input  logic            fill_start,
  input  logic [DATA-1:0] fill_data,
  output logic            fill_done,
  output logic            busy,
  output logic            ram_en_,
  output logic            ram_rw_,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_wdata,
  input  logic [DATA-1:0] ram_rdata
);

  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

  ram_ctrl_state_t state;
  logic [ADDR-1:0] counter;
  logic [DATA-1:0] fill_reg;

  // fill_start has priority over a request; nothing is accepted during reset
  assign req_ready  = reset && (state == IDLE) && !fill_start;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      resp_rdata <= '0;
      fill_done  <= 1'b0;
      counter    <= '0;
      fill_reg   <= '0;
    end else begin
      fill_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fill_start) begin
            fill_reg <= fill_data;
            counter  <= '0;
            state    <= FILL;
          end else if (req_valid && req_rw_) begin
            if (OUTREG) begin
              state <= RD_WAIT;
            end else begin
              resp_rdata <= ram_rdata;
              state      <= RESP;
            end
          end
        end
        FILL: begin
          // explicit terminal compare so non-power-of-2 depths never wrap
          if (counter == LAST) begin
            counter   <= '0;
            fill_done <= 1'b1;
            state     <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RD_WAIT: begin
          resp_rdata <= ram_rdata;
          state      <= RESP;
        end
        RESP: begin
          // clearing here keeps resp_rdata zero outside RESP
          if (resp_ready) begin
            resp_rdata <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en_   = 1'b1;
    ram_rw_   = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    if (reset) begin
      if (state == FILL) begin
        ram_en_   = 1'b0;
        ram_rw_   = 1'b0;
        ram_addr  = counter;
        ram_wdata = fill_reg;
      end else if (req_ready && req_valid) begin
        ram_en_  = 1'b0;
        ram_rw_  = req_rw_;
        ram_addr = req_addr;
        if (!req_rw_) begin
          ram_wdata = req_wdata;
        end
      end
    end
  end

endmodule
